nn_job_scheduler: RTL and testbench

//  Shares one nn inference core between NREQ requesters. Round-robin arbitration, one job in flight.
//  Per job: holds the operands stable on the core inputs, pulses nn enable for one cycle, waits a

---
 rtl/nn_job_scheduler.sv | 154 +++++++++++++++
 tb/tb_nn_job_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_job_scheduler.sv
// nn_job_scheduler: round-robin front end sharing one nn inference core.
// One job in flight: grant, issue, fixed-latency wait, respond.
module nn_job_scheduler #(
    parameter int NREQ     = 2,
    parameter int COLD_LAT = 18,
    parameter int WARM_LAT = 6,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW = $clog2(COLD_LAT + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*32-1:0]   req_in1_i,
    input  logic [NREQ*32-1:0]   req_in2_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [31:0]          rsp_data_o,
    output logic                 rsp_ovf_o,
    output logic                 rsp_zero_o,
    output logic [2:0]           rsp_ovf_stage_o,
    output logic [2:0]           rsp_zero_stage_o,
    output logic                 nn_enable_o,
    output logic [31:0]          nn_input_1_o,
    output logic [31:0]          nn_input_2_o,
    input  logic [31:0]          nn_result_i,
    input  logic                 nn_ovf_i,
    input  logic                 nn_zero_i,
    input  logic [2:0]           nn_ovf_stage_i,
    input  logic [2:0]           nn_zero_stage_i,
    output logic                 busy_o,
    output logic [IW-1:0]        grant_id_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   grant_id_q;
    logic [CW-1:0]   cnt_q;
    logic            cold_q;
    logic            nn_enable_q;
    logic            busy_q;
    logic [31:0]     in1_q;
    logic [31:0]     in2_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [31:0]     rsp_data_q;
    logic            rsp_ovf_q;
    logic            rsp_zero_q;
    logic [2:0]      rsp_ovf_stage_q;
    logic [2:0]      rsp_zero_stage_q;

    logic [IW-1:0]   gnt_d;
    logic            any_d;
    logic [IW:0]     idx_c;

    // Pick the first valid requester at or after ptr_q+1, wrapping at NREQ
    always_comb begin
        gnt_d = ptr_q;
        any_d = 1'b0;
        idx_c = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx_c = {1'b0, ptr_q} + (IW+1)'(k);
            if (idx_c >= (IW+1)'(NREQ))
                idx_c = idx_c - (IW+1)'(NREQ);
            if (req_valid_i[idx_c[IW-1:0]]) begin
                gnt_d = idx_c[IW-1:0];
                any_d = 1'b1;
            end
        end
    end

    assign req_ready_o = (state_q == S_IDLE && any_d) ?
                         (NREQ'(1) << gnt_d) : '0;

    // Job sequencing: grant, one-cycle enable, latency count, response hold
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= S_IDLE;
            ptr_q            <= IW'(NREQ - 1);
            grant_id_q       <= '0;
            cnt_q            <= '0;
            cold_q           <= 1'b1;
            nn_enable_q      <= 1'b0;
            busy_q           <= 1'b0;
            in1_q            <= '0;
            in2_q            <= '0;
            rsp_valid_q      <= '0;
            rsp_data_q       <= '0;
            rsp_ovf_q        <= 1'b0;
            rsp_zero_q       <= 1'b0;
            rsp_ovf_stage_q  <= 3'b111;
            rsp_zero_stage_q <= 3'b111;
        end else begin
            nn_enable_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (any_d) begin
                        in1_q       <= req_in1_i[32*gnt_d +: 32];
                        in2_q       <= req_in2_i[32*gnt_d +: 32];
                        grant_id_q  <= gnt_d;
                        ptr_q       <= gnt_d;
                        nn_enable_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= cold_q ? CW'(COLD_LAT) : CW'(WARM_LAT);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        rsp_data_q       <= nn_result_i;
                        rsp_ovf_q        <= nn_ovf_i;
                        rsp_zero_q       <= nn_zero_i;
                        rsp_ovf_stage_q  <= nn_ovf_stage_i;
                        rsp_zero_stage_q <= nn_zero_stage_i;
                        cold_q           <= 1'b0;
                        rsp_valid_q      <= NREQ'(1) << grant_id_q;
                        state_q          <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i[grant_id_q]) begin
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_data_o       = rsp_data_q;
    assign rsp_ovf_o        = rsp_ovf_q;
    assign rsp_zero_o       = rsp_zero_q;
    assign rsp_ovf_stage_o  = rsp_ovf_stage_q;
    assign rsp_zero_stage_o = rsp_zero_stage_q;
    assign nn_enable_o      = nn_enable_q;
    assign nn_input_1_o     = in1_q;
    assign nn_input_2_o     = in2_q;
    assign busy_o           = busy_q;
    assign grant_id_o       = grant_id_q;

endmodule

// File: tb/tb_nn_job_scheduler.sv
// tb_nn_job_scheduler: bench for nn_job_scheduler with a behavioural
// nn core stand-in and a round-robin / latency reference model.
module tb_nn_job_scheduler;

    localparam int NREQ = 2;
    localparam int COLD = 18;
    localparam int WARM = 6;

    logic            clk;
    logic            resetn;
    logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*32-1:0] req_in1, req_in2;
    logic [31:0]     rsp_data, nn_input_1, nn_input_2, nn_result;
    logic            rsp_ovf, rsp_zero, nn_enable, nn_ovf, nn_zero, busy;
    logic [2:0]      rsp_ovf_stage, rsp_zero_stage, nn_ovf_stage, nn_zero_stage;
    logic [0:0]      grant_id;

    int checks = 0;
    int errors = 0;
    int mptr;
    bit mcold;

    typedef struct {
        logic [31:0] d;
        logic        ovf;
        logic        zero;
        logic [2:0]  os;
        logic [2:0]  zs;
    } res_t;

    nn_job_scheduler #(.NREQ(NREQ), .COLD_LAT(COLD), .WARM_LAT(WARM)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_in1_i(req_in1), .req_in2_i(req_in2),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_ovf_o(rsp_ovf), .rsp_zero_o(rsp_zero),
        .rsp_ovf_stage_o(rsp_ovf_stage), .rsp_zero_stage_o(rsp_zero_stage),
        .nn_enable_o(nn_enable), .nn_input_1_o(nn_input_1),
        .nn_input_2_o(nn_input_2), .nn_result_i(nn_result),
        .nn_ovf_i(nn_ovf), .nn_zero_i(nn_zero),
        .nn_ovf_stage_i(nn_ovf_stage), .nn_zero_stage_i(nn_zero_stage),
        .busy_o(busy), .grant_id_o(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core arithmetic: in1 * (18*in2 + 3), saturating at 32 bits
    function automatic res_t ref_job(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        logic [63:0] m, p;
        m = 64'(b) * 64'd18 + 64'd3;
        p = 64'(a) * m;
        r.ovf  = (p[63:32] != 32'd0);
        r.d    = r.ovf ? 32'hFFFFFFFF : p[31:0];
        r.zero = !r.ovf && (r.d == 32'd0);
        r.os   = r.ovf ? 3'b011 : 3'b111;
        r.zs   = r.zero ? 3'b010 : 3'b111;
        return r;
    endfunction

    // Core stand-in: garbage outputs until its internal latency elapses
    int          c_cnt;
    bit          c_cold;
    logic [31:0] c_a, c_b, junk;
    res_t        c_r;
    always @(posedge clk) junk <= $urandom;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c_cnt <= 0; c_cold <= 1'b1; c_a <= '0; c_b <= '0;
        end else if (nn_enable) begin
            c_a <= nn_input_1; c_b <= nn_input_2;
            c_cnt <= c_cold ? 15 : 5;
        end else if (c_cnt != 0) begin
            c_cnt <= c_cnt - 1;
            if (c_cnt == 1) c_cold <= 1'b0;
        end
    end
    always_comb begin
        c_r = ref_job(c_a, c_b);
        nn_result     = (c_cnt == 0) ? c_r.d    : junk;
        nn_ovf        = (c_cnt == 0) ? c_r.ovf  : junk[0];
        nn_zero       = (c_cnt == 0) ? c_r.zero : junk[1];
        nn_ovf_stage  = (c_cnt == 0) ? c_r.os   : junk[4:2];
        nn_zero_stage = (c_cnt == 0) ? c_r.zs   : junk[7:5];
    end

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_valid[idx] = 1'b1;
        req_in1[32*idx +: 32] = a;
        req_in2[32*idx +: 32] = b;
    endtask

    task automatic wait_rsp(input int idx, output int n, output int en,
                            output bit st, output bit to);
        logic [31:0] a0, b0;
        n = 0; en = 0; st = 1'b1; to = 1'b1; a0 = '0; b0 = '0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            n = i;
            if (i == 1) begin a0 = nn_input_1; b0 = nn_input_2; end
            if (nn_enable) en++;
            if (nn_input_1 !== a0 || nn_input_2 !== b0) st = 1'b0;
            if (rsp_valid[idx]) begin to = 1'b0; break; end
        end
    endtask

    task automatic do_job(input int idx, input logic [31:0] a, input logic [31:0] b,
                          output logic [NREQ-1:0] rr, output int n, output int en,
                          output bit st, output bit to);
        @(negedge clk);
        set_req(idx, a, b);
        #1 rr = req_ready;
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
        wait_rsp(idx, n, en, st, to);
    endtask

    task automatic finish_rsp(input int idx);
        rsp_ready[idx] = 1'b1;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = '0; rsp_ready = '0;
        req_in1 = '0; req_in2 = '0;
        repeat (3) @(negedge clk);
        checks++; if ({req_ready, rsp_valid, nn_enable, busy, grant_id} !== '0) begin errors++; $display("FAIL reset_ctl got %b", {req_ready, rsp_valid, nn_enable, busy, grant_id}); end
        checks++; if ({rsp_data, rsp_ovf, rsp_zero} !== '0) begin errors++; $display("FAIL reset_rsp got %h", {rsp_data, rsp_ovf, rsp_zero}); end
        checks++; if ({rsp_ovf_stage, rsp_zero_stage} !== 6'b111111) begin errors++; $display("FAIL reset_stage got %b want 111111", {rsp_ovf_stage, rsp_zero_stage}); end
        checks++; if ({nn_input_1, nn_input_2} !== 64'd0) begin errors++; $display("FAIL reset_inputs got %h", {nn_input_1, nn_input_2}); end
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        mptr = NREQ - 1; mcold = 1'b1;
    endtask

    task automatic test_cold_warm();
        logic [NREQ-1:0] rr;
        int n, en, lat;
        bit st, to;
        for (int j = 0; j < 2; j++) begin
            lat = mcold ? COLD : WARM;
            do_job(0, 32'd8, 32'd6, rr, n, en, st, to);
            mptr = 0; mcold = 1'b0;
            checks++; if (rr !== 2'b01) begin errors++; $display("FAIL job%0d_req_ready got %b want 01", j, rr); end
            checks++; if (to || n != 2 + lat) begin errors++; $display("FAIL job%0d_latency got %0d want %0d", j, n, 2 + lat); end
            checks++; if (en != 1 || !st) begin errors++; $display("FAIL job%0d_issue en=%0d stable=%0d want 1 1", j, en, st); end
            checks++; if (rsp_data !== 32'd888) begin errors++; $display("FAIL job%0d_data got %0d want 888", j, rsp_data); end
            checks++; if ({rsp_ovf, rsp_zero, rsp_ovf_stage, rsp_zero_stage} !== 8'b00111111) begin errors++; $display("FAIL job%0d_flags got %b want 00111111", j, {rsp_ovf, rsp_zero, rsp_ovf_stage, rsp_zero_stage}); end
            checks++; if (rsp_valid !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL job%0d_rsp_valid got %b busy %b", j, rsp_valid, busy); end
            finish_rsp(0);
            checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL job%0d_done got %b busy %b want 00 0", j, rsp_valid, busy); end
        end
    endtask

    task automatic test_round_robin();
        int exp, prev, n, en;
        bit st, to;
        res_t r;
        @(negedge clk);
        set_req(0, 32'd3, 32'd1);
        set_req(1, 32'd5, 32'd2);
        prev = mptr;
        for (int j = 0; j < 4; j++) begin
            exp = rr_pick(mptr, req_valid);
            #1;
            checks++; if (req_ready !== NREQ'(1 << exp)) begin errors++; $display("FAIL rr%0d_ready got %b want %b", j, req_ready, NREQ'(1 << exp)); end
            @(posedge clk); #1;
            checks++; if (int'(grant_id) != exp || exp == prev) begin errors++; $display("FAIL rr%0d_grant got %0d want %0d prev %0d", j, grant_id, exp, prev); end
            prev = exp; mptr = exp;
            wait_rsp(exp, n, en, st, to);
            r = ref_job(req_in1[32*exp +: 32], req_in2[32*exp +: 32]);
            checks++; if (to || n != 2 + WARM || rsp_data !== r.d) begin errors++; $display("FAIL rr%0d_rsp lat %0d data %0d want %0d %0d", j, n, rsp_data, 2 + WARM, r.d); end
            finish_rsp(exp);
        end
        req_valid = '0;
    endtask

    task automatic test_overflow();
        logic [NREQ-1:0] rr;
        int n, en;
        bit st, to;
        do_job(0, 32'h7FFFFFFF, 32'd6, rr, n, en, st, to);
        mptr = 0;
        checks++; if (to || rsp_data !== 32'hFFFFFFFF || rsp_ovf !== 1'b1) begin errors++; $display("FAIL ovf_data got %h ovf %b want ffffffff 1", rsp_data, rsp_ovf); end
        checks++; if (rsp_ovf_stage !== 3'b011) begin errors++; $display("FAIL ovf_stage got %b want 011", rsp_ovf_stage); end
        finish_rsp(0);
        do_job(1, 32'd0, 32'd9, rr, n, en, st, to);
        mptr = 1;
        checks++; if (to || rsp_valid !== 2'b10 || rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_zero_stage !== 3'b010) begin errors++; $display("FAIL zero_job got v=%b d=%0d z=%b zs=%b want 10 0 1 010", rsp_valid, rsp_data, rsp_zero, rsp_zero_stage); end
        finish_rsp(1);
    endtask

    task automatic test_backpressure();
        int exp, n, en;
        bit st, to;
        res_t r;
        @(negedge clk);
        set_req(0, 32'd11, 32'd4);
        set_req(1, 32'd13, 32'd7);
        exp = rr_pick(mptr, req_valid);
        @(posedge clk); #1;
        mptr = exp;
        wait_rsp(exp, n, en, st, to);
        r = ref_job(req_in1[32*exp +: 32], req_in2[32*exp +: 32]);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got none want rsp"); end
        rsp_ready[1 - exp] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== NREQ'(1 << exp) || rsp_data !== r.d || req_ready !== '0 || int'(grant_id) != exp || nn_enable !== 1'b0) begin errors++; $display("FAIL bp_hold%0d v=%b d=%0d rr=%b g=%0d want %b %0d 00 %0d", i, rsp_valid, rsp_data, req_ready, grant_id, NREQ'(1 << exp), r.d, exp); end
        end
        rsp_ready = '0;
        finish_rsp(exp);
        #1;
        checks++; if (req_ready !== NREQ'(1 << (1 - exp))) begin errors++; $display("FAIL bp_next got %b want %b", req_ready, NREQ'(1 << (1 - exp))); end
        req_valid = '0;
    endtask

    task automatic test_mid_reset();
        logic [NREQ-1:0] rr;
        int n, en;
        bit st, to;
        @(negedge clk);
        set_req(1, 32'd2, 32'd2);
        @(posedge clk); #1 req_valid = '0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
        resetn = 1'b0;
        #1;
        checks++; if ({req_ready, rsp_valid, nn_enable, busy, grant_id, rsp_data, nn_input_1, nn_input_2} !== '0) begin errors++; $display("FAIL mid_reset_outputs not zero busy=%b en=%b g=%0d", busy, nn_enable, grant_id); end
        @(negedge clk);
        resetn = 1'b1;
        mptr = NREQ - 1; mcold = 1'b1;
        do_job(0, 32'd8, 32'd6, rr, n, en, st, to);
        mptr = 0; mcold = 1'b0;
        checks++; if (to || n != 2 + COLD || rsp_data !== 32'd888) begin errors++; $display("FAIL mid_cold lat %0d data %0d want %0d 888", n, rsp_data, 2 + COLD); end
        finish_rsp(0);
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pend;
        logic [31:0] pa [NREQ];
        logic [31:0] pb [NREQ];
        int exp, n, en, hold;
        bit st, to;
        res_t r;
        pend = '0;
        for (int j = 0; j < 40; j++) begin
            for (int q = 0; q < NREQ; q++) begin
                if (!pend[q] && $urandom_range(0, 2) != 0) begin
                    pend[q] = 1'b1;
                    case ($urandom_range(0, 3))
                        0: pa[q] = 32'd0;
                        1: pa[q] = $urandom;
                        default: pa[q] = $urandom_range(1, 1000);
                    endcase
                    pb[q] = $urandom_range(0, 20);
                end
            end
            if (pend == '0) begin
                req_valid = '0;
                @(negedge clk);
                continue;
            end
            for (int q = 0; q < NREQ; q++)
                if (pend[q]) set_req(q, pa[q], pb[q]);
            exp = rr_pick(mptr, pend);
            #1;
            checks++; if (req_ready !== NREQ'(1 << exp)) begin errors++; $display("FAIL rnd%0d_ready got %b want %b", j, req_ready, NREQ'(1 << exp)); end
            @(posedge clk); #1;
            checks++; if (int'(grant_id) != exp) begin errors++; $display("FAIL rnd%0d_grant got %0d want %0d", j, grant_id, exp); end
            mptr = exp; pend[exp] = 1'b0; req_valid[exp] = 1'b0;
            wait_rsp(exp, n, en, st, to);
            r = ref_job(pa[exp], pb[exp]);
            checks++; if (to || n != 2 + WARM || en != 1 || !st) begin errors++; $display("FAIL rnd%0d_timing lat %0d en %0d st %0d want %0d 1 1", j, n, en, st, 2 + WARM); end
            checks++; if ({rsp_data, rsp_ovf, rsp_zero, rsp_ovf_stage, rsp_zero_stage} !== {r.d, r.ovf, r.zero, r.os, r.zs}) begin errors++; $display("FAIL rnd%0d_rsp got %h %b%b %b %b want %h %b%b %b %b", j, rsp_data, rsp_ovf, rsp_zero, rsp_ovf_stage, rsp_zero_stage, r.d, r.ovf, r.zero, r.os, r.zs); end
            hold = $urandom_range(0, 3);
            rsp_ready[1 - exp] = 1'b1;
            repeat (hold) @(negedge clk);
            rsp_ready = '0;
            finish_rsp(exp);
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_cold_warm();
        test_round_robin();
        test_overflow();
        test_backpressure();
        test_mid_reset();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
